// File: rtl/msa_pkg.sv
// Shared definitions for the MSA beat sequencer: format codes, FSM states,
// op classes and the decode-time classification helper.
package msa_pkg;

    localparam int VEC_W  = 128;
    localparam int LANE_W = 32;
    localparam int BEATS  = VEC_W / LANE_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int MEM_TO = 15;
    localparam int TO_W   = $clog2(MEM_TO + 1);

    localparam logic [3:0] FMT_I8     = 4'd0;
    localparam logic [3:0] FMT_I5     = 4'd1;
    localparam logic [3:0] FMT_I10    = 4'd2;
    localparam logic [3:0] FMT_BIT    = 4'd3;
    localparam logic [3:0] FMT_3R     = 4'd4;
    localparam logic [3:0] FMT_ELM    = 4'd5;
    localparam logic [3:0] FMT_3RF    = 4'd6;
    localparam logic [3:0] FMT_2R     = 4'd7;
    localparam logic [3:0] FMT_2RF    = 4'd8;
    localparam logic [3:0] FMT_VEC    = 4'd9;
    localparam logic [3:0] FMT_BRANCH = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ELM  = 2'd1,
        CLS_VEC  = 2'd2,
        CLS_MEM  = 2'd3
    } op_class_e;

    typedef struct packed {
        op_class_e  cls;
        logic       is_store;
        logic [4:0] wd;
        logic [4:0] ws;
        logic [4:0] wt;
    } op_t;

    // Undefined format codes fall into CLS_NONE so they retire without datapath activity.
    function automatic op_class_e classify(input logic [3:0] fmt, input logic is_mem);
        op_class_e cls;
        if (is_mem) begin
            cls = CLS_MEM;
        end else begin
            case (fmt)
                FMT_ELM:    cls = CLS_ELM;
                FMT_I8, FMT_I5, FMT_I10, FMT_BIT, FMT_3R,
                FMT_3RF, FMT_2R, FMT_2RF, FMT_VEC:
                            cls = CLS_VEC;
                FMT_BRANCH: cls = CLS_NONE;
                default:    cls = CLS_NONE;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/msa_beat_sequencer_if.sv
// Decode-side handshake plus VRF / lane ALU / memory port controls of the sequencer.
interface msa_beat_sequencer_if;

    logic                         in_valid;
    logic                         in_ready;
    logic [3:0]                   fmt;
    logic                         is_mem;
    logic                         is_store;
    logic [4:0]                   wd;
    logic [4:0]                   ws;
    logic [4:0]                   wt;
    logic [msa_pkg::BEAT_W-1:0]   vrf_beat;
    logic                         vrf_we;
    logic [4:0]                   vrf_wd;
    logic [4:0]                   vrf_ws;
    logic [4:0]                   vrf_wt;
    logic                         alu_go;
    logic                         mem_req;
    logic                         mem_we;
    logic                         mem_ack;
    logic                         busy;
    logic                         retire;
    logic                         err;

    modport master (
        output in_valid, fmt, is_mem, is_store, wd, ws, wt, mem_ack,
        input  in_ready, vrf_beat, vrf_we, vrf_wd, vrf_ws, vrf_wt,
               alu_go, mem_req, mem_we, busy, retire, err
    );

    modport slave (
        input  in_valid, fmt, is_mem, is_store, wd, ws, wt, mem_ack,
        output in_ready, vrf_beat, vrf_we, vrf_wd, vrf_ws, vrf_wt,
               alu_go, mem_req, mem_we, busy, retire, err
    );

endinterface

// File: rtl/msa_beat_counter.sv
// Beat index with wrap / last-beat flag, and the memory-wait timeout counter.
module msa_beat_counter
    import msa_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              beat_clr,
    input  logic              beat_inc,
    input  logic              to_clr,
    input  logic              to_inc,
    output logic [BEAT_W-1:0] beat,
    output logic              last_beat,
    output logic              to_expire
);

    logic [BEAT_W-1:0] beat_r;
    logic [TO_W-1:0]   to_cnt_r;

    // Beat index: clear wins, increment wraps back to 0 after the last beat
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat_r <= '0;
        end else if (beat_clr) begin
            beat_r <= '0;
        end else if (beat_inc) begin
            if (beat_r == BEAT_W'(BEATS - 1)) begin
                beat_r <= '0;
            end else begin
                beat_r <= beat_r + BEAT_W'(1);
            end
        end else begin
            beat_r <= beat_r;
        end
    end

    // Timeout counter: counts unacknowledged request cycles, cleared on ack or exit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_cnt_r <= '0;
        end else if (to_clr) begin
            to_cnt_r <= '0;
        end else if (to_inc) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    assign beat      = beat_r;
    assign last_beat = (beat_r == BEAT_W'(BEATS - 1));
    // Asserted during the MEM_TO-th consecutive wait cycle, so the abort fires on that cycle
    assign to_expire = (to_cnt_r == TO_W'(MEM_TO - 1));

endmodule

// File: rtl/msa_beat_sequencer.sv
// Multi-cycle issue controller splitting a 128-bit MSA op into 32-bit beats
// for the lane ALU or the memory port, then pulsing retire.
module msa_beat_sequencer
    import msa_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    msa_beat_sequencer_if.slave   bus
);

    state_e            state_r;
    state_e            state_s;
    op_t               op_r;
    logic              accept_s;
    logic              abort_s;
    logic              beat_clr_s;
    logic              beat_inc_s;
    logic              to_clr_s;
    logic              to_inc_s;
    logic              last_beat_s;
    logic              to_expire_s;
    logic [BEAT_W-1:0] beat_s;

    assign accept_s = bus.in_valid && (state_r == ST_IDLE);
    assign abort_s  = (state_r == ST_MEM) && !bus.mem_ack && to_expire_s;

    msa_beat_counter u_beat_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .beat_clr  (beat_clr_s),
        .beat_inc  (beat_inc_s),
        .to_clr    (to_clr_s),
        .to_inc    (to_inc_s),
        .beat      (beat_s),
        .last_beat (last_beat_s),
        .to_expire (to_expire_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Op latch: class is resolved once at accept, so later fmt changes are irrelevant
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_r <= '0;
        end else if (accept_s) begin
            op_r <= '{cls: classify(bus.fmt, bus.is_mem), is_store: bus.is_store,
                      wd: bus.wd, ws: bus.ws, wt: bus.wt};
        end else begin
            op_r <= op_r;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    case (classify(bus.fmt, bus.is_mem))
                        CLS_MEM:          state_s = ST_MEM;
                        CLS_ELM, CLS_VEC: state_s = ST_EXEC;
                        default:          state_s = ST_DONE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (last_beat_s || (op_r.cls == CLS_ELM)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_MEM: begin
                if (bus.mem_ack && last_beat_s) begin
                    state_s = ST_DONE;
                end else if (abort_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_MEM;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output and beat/timeout counter control decode
    always_comb begin
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        bus.alu_go   = 1'b0;
        bus.vrf_we   = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.retire   = 1'b0;
        bus.err      = 1'b0;
        bus.vrf_beat = beat_s;
        bus.vrf_wd   = 5'd0;
        bus.vrf_ws   = 5'd0;
        bus.vrf_wt   = 5'd0;
        beat_clr_s   = 1'b0;
        beat_inc_s   = 1'b0;
        to_clr_s     = 1'b1;
        to_inc_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
            end
            ST_EXEC: begin
                bus.busy   = 1'b1;
                bus.alu_go = 1'b1;
                bus.vrf_we = 1'b1;
                bus.vrf_wd = op_r.wd;
                bus.vrf_ws = op_r.ws;
                bus.vrf_wt = op_r.wt;
                beat_inc_s = (op_r.cls != CLS_ELM);
            end
            ST_MEM: begin
                bus.busy    = 1'b1;
                bus.mem_req = 1'b1;
                bus.mem_we  = op_r.is_store;
                bus.vrf_we  = bus.mem_ack && !op_r.is_store;
                bus.err     = abort_s;
                bus.vrf_wd  = op_r.wd;
                bus.vrf_ws  = op_r.ws;
                bus.vrf_wt  = op_r.wt;
                beat_inc_s  = bus.mem_ack;
                beat_clr_s  = abort_s;
                to_clr_s    = bus.mem_ack || abort_s;
                to_inc_s    = !bus.mem_ack && !abort_s;
            end
            ST_DONE: begin
                bus.busy   = 1'b1;
                bus.retire = 1'b1;
                bus.vrf_wd = op_r.wd;
                bus.vrf_ws = op_r.ws;
                bus.vrf_wt = op_r.wt;
                beat_clr_s = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_msa_beat_sequencer.sv
// Scoreboard bench: stimulus derives expected beat/retire/err events from the op rules,
// a negedge monitor pops and compares them as the sequencer presents them.
module tb_msa_beat_sequencer;

    localparam int K_ALU = 0;
    localparam int K_MEM = 1;
    localparam int K_RET = 2;
    localparam int K_ERR = 3;

    typedef struct {
        int          kind;
        int          beat;
        bit          we;
        logic [14:0] regs;
        int          at;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    ev_t  exp_q[$];
    ev_t  mon_e;

    msa_beat_sequencer_if bus();

    msa_beat_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic push(input int kind, input int beat, input bit we, input logic [14:0] regs, input int at);
        ev_t e;
        e.kind = kind; e.beat = beat; e.we = we; e.regs = regs; e.at = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every datapath/completion event must match the head of the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.alu_go || (bus.mem_req && bus.mem_ack) || bus.retire || bus.err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ev_kind", bus.err ? K_ERR : bus.retire ? K_RET : bus.alu_go ? K_ALU : K_MEM, mon_e.kind);
                    chk("ev_cycle", cyc, mon_e.at);
                    if (mon_e.kind == K_ALU) begin
                        chk("alu_beat", {30'd0, bus.vrf_beat}, mon_e.beat);
                        chk("alu_we_req", {30'd0, bus.vrf_we, bus.mem_req}, 32'd2);
                        chk("alu_regs", {17'd0, bus.vrf_wd, bus.vrf_ws, bus.vrf_wt}, {17'd0, mon_e.regs});
                    end else if (mon_e.kind == K_MEM) begin
                        chk("mem_beat", {30'd0, bus.vrf_beat}, mon_e.beat);
                        chk("mem_we_vrf_we", {30'd0, bus.mem_we, bus.vrf_we}, {30'd0, mon_e.we, !mon_e.we});
                        chk("mem_regs", {17'd0, bus.vrf_wd, bus.vrf_ws, bus.vrf_wt}, {17'd0, mon_e.regs});
                    end else if (mon_e.kind == K_ERR) begin
                        chk("err_mem_we", {31'd0, bus.mem_we}, {31'd0, mon_e.we});
                    end else begin
                        chk("retire_quiet", {29'd0, bus.alu_go, bus.vrf_we, bus.mem_req}, 32'd0);
                    end
                end
            end else if (bus.mem_req) begin
                chk("wait_vrf_we", {31'd0, bus.vrf_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                end else begin
                    chk("wait_beat", {30'd0, bus.vrf_beat}, exp_q[0].beat);
                    chk("wait_mem_we", {31'd0, bus.mem_we}, {31'd0, exp_q[0].we});
                end
            end
        end
    end

    task automatic idle_outputs(input string name);
        chk(name, {22'd0, bus.in_ready, bus.busy, bus.alu_go, bus.vrf_we, bus.mem_req,
                   bus.mem_we, bus.retire, bus.err, bus.vrf_beat}, 32'h200);
    endtask

    // Issues one op in the current (idle) cycle; dly holds 4-bit ack delays per beat,
    // abort_beat >= 0 withholds that beat's ack, rst_at > 0 pulls reset in that cycle.
    task automatic run_op(input logic [3:0] f, input logic m, input logic st,
                          input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                          input logic [15:0] dly, input int abort_beat, input int rst_at);
        int          c;
        int          len;
        int          tt;
        int          dd;
        bit          ack_at[64];
        logic [14:0] regs;
        c    = cyc;
        regs = {d, s, t};
        foreach (ack_at[i]) ack_at[i] = 1'b0;
        reset_n      = 1'b1;
        bus.in_valid = 1'b1;
        bus.fmt = f; bus.is_mem = m; bus.is_store = st;
        bus.wd = d; bus.ws = s; bus.wt = t;
        bus.mem_ack  = 1'($urandom_range(0, 1));
        len = 0;
        if (m) begin
            tt = 1;
            for (int i = 0; i < 4; i++) begin
                if (len == 0) begin
                    if (i == abort_beat) begin
                        len = tt + 14;
                        push(K_ERR, i, st, regs, c + len);
                    end else begin
                        dd = int'(dly[i*4 +: 4]);
                        ack_at[tt + dd] = 1'b1;
                        push(K_MEM, i, st, regs, c + tt + dd);
                        tt = tt + dd + 1;
                    end
                end
            end
            if (len == 0) begin
                len = tt;
                push(K_RET, 0, 1'b0, regs, c + len);
            end
        end else if (f == 4'd5) begin
            push(K_ALU, 0, 1'b0, regs, c + 1);
            push(K_RET, 0, 1'b0, regs, c + 2);
            len = 2;
        end else if (f <= 4'd9) begin
            len = (rst_at > 0) ? rst_at : 5;
            for (int i = 0; i < 4; i++) begin
                if (i + 1 <= len) push(K_ALU, i, 1'b0, regs, c + 1 + i);
            end
            if (rst_at == 0) push(K_RET, 0, 1'b0, regs, c + 5);
        end else begin
            push(K_RET, 0, 1'b0, regs, c + 1);
            len = 1;
        end
        for (int n = 1; n <= len; n++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.fmt = 4'($urandom); bus.is_mem = 1'($urandom); bus.is_store = 1'($urandom);
            bus.wd = 5'($urandom); bus.ws = 5'($urandom); bus.wt = 5'($urandom);
            bus.mem_ack = m ? ack_at[n] : 1'($urandom_range(0, 1));
            if (n == rst_at) begin
                reset_n = 1'b0;
                bus.in_valid = 1'b1;
                bus.fmt = 4'd7; bus.is_mem = 1'b0; bus.wd = 5'd9; bus.ws = 5'd10; bus.wt = 5'd11;
            end
        end
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        logic [3:0]  f;
        logic        m;
        logic [15:0] dl;
        int          ab;
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.fmt = 4'd0; bus.is_mem = 1'b0; bus.is_store = 1'b0;
        bus.wd = 5'd0; bus.ws = 5'd0; bus.wt = 5'd0; bus.mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle_outputs("reset_state");
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clk); #1;

        run_op(4'd4,  1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 16'h0000, -1, 0);
        run_op(4'd5,  1'b0, 1'b0, 5'd4, 5'd5, 5'd6, 16'h0000, -1, 0);
        run_op(4'd11, 1'b0, 1'b0, 5'd7, 5'd8, 5'd9, 16'h0000, -1, 0);
        run_op(4'd2,  1'b1, 1'b0, 5'd12, 5'd13, 5'd14, 16'h1020, -1, 0);
        run_op(4'd2,  1'b1, 1'b1, 5'd15, 5'd16, 5'd17, 16'h0000, 0, 0);
        run_op(4'd4,  1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 16'h0000, -1, 3);
        idle_outputs("after_mid_reset");
        run_op(4'd7,  1'b0, 1'b0, 5'd9, 5'd10, 5'd11, 16'h0000, -1, 0);
        run_op(4'd13, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0000, -1, 0);
        run_op(4'd11, 1'b1, 1'b0, 5'd20, 5'd21, 5'd22, 16'h3333, -1, 0);

        for (int k = 0; k < 80; k++) begin
            f  = 4'($urandom_range(0, 15));
            m  = ($urandom_range(0, 9) < 3);
            dl = 16'($urandom);
            dl = dl & 16'h3333;
            ab = (m && ($urandom_range(0, 4) == 0)) ? $urandom_range(0, 3) : -1;
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            run_op(f, m, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), dl, ab, 0);
        end

        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
